// File: rtl/lightcube8_ctrl.sv
// 8x8x8 LED cube controller: UART frame receiver with echo, double-buffered
// frame store, walking-layer demo source and layer-multiplexed scan driver.
module lightcube8_ctrl #(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned FRAME_TIMEOUT = 16384,
    parameter int unsigned LAYER_CLKS    = 12500,
    parameter int unsigned DEMO_CLKS     = 25_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] switch,
    input  logic        rx,
    output logic        tx,
    output logic [7:0]  high_csn,
    output logic [7:0]  row,
    output logic [7:0]  row_cs
);
    localparam int unsigned BIT_CLKS  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
    localparam int unsigned BW = $clog2(BIT_CLKS);
    localparam int unsigned IW = $clog2(FRAME_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LAYER_CLKS);
    localparam int unsigned DW = $clog2(DEMO_CLKS);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    logic unused_switch;
    assign unused_switch = ^switch[15:1];

    logic rx_meta, rx_sync, rx_prev, mode_meta, mode_sync, mode_prev;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            mode_meta <= 1'b0;
            mode_sync <= 1'b0;
            mode_prev <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            mode_meta <= switch[0];
            mode_sync <= mode_meta;
            mode_prev <= mode_sync;
        end
    end

    rx_state_t     rx_state, rx_next;
    logic [BW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_half, rx_full, byte_valid;

    assign rx_half = (rx_cnt == BW'(HALF_CLKS - 1));
    assign rx_full = (rx_cnt == BW'(BIT_CLKS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:      if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START:     if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_full && rx_bit == 4'd8) rx_next = RX_STOP;
            RX_STOP:      if (rx_full) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (rx_state == RX_STOP) && rx_full && rx_sync;
    end

    // Bit 8 is the extra slot: it advances rx_bit but is not shifted in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_state != rx_next || rx_full) rx_cnt <= '0;
            else rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end else if (rx_state == RX_DATA && rx_full) begin
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit < 4'd8) rx_shift <= {rx_sync, rx_shift[7:1]};
            end
        end
    end

    logic          tx_busy, tx_load, hold_valid;
    logic [10:0]   tx_shift;
    logic [BW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic [7:0]    hold_data, tx_load_data;

    always_comb begin
        tx_load      = 1'b0;
        tx_load_data = rx_shift;
        if (!tx_busy) begin
            if (hold_valid) begin
                tx_load      = 1'b1;
                tx_load_data = hold_data;
            end else if (byte_valid) begin
                tx_load = 1'b1;
            end
        end
    end

    // The shifter refills with ones, so its LSB idles high between frames.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_shift   <= '1;
            tx_busy    <= 1'b0;
            tx_cnt     <= '0;
            tx_bits    <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            if (tx_load) begin
                tx_shift <= {1'b1, tx_load_data[0], tx_load_data, 1'b0};
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
                tx_bits  <= '0;
            end else if (tx_busy) begin
                if (tx_cnt == BW'(BIT_CLKS - 1)) begin
                    tx_cnt   <= '0;
                    tx_shift <= {1'b1, tx_shift[10:1]};
                    if (tx_bits == 4'd10) tx_busy <= 1'b0;
                    else                  tx_bits <= tx_bits + 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
            if (!tx_busy && hold_valid) begin
                hold_valid <= byte_valid;
                if (byte_valid) hold_data <= rx_shift;
            end else if (byte_valid && !tx_load && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= rx_shift;
            end
        end
    end

    assign tx = tx_shift[0];

    logic [7:0]    frame_buf [2][64];
    logic [5:0]    byte_idx;
    logic          wr_sel, swap_pend, mode_change;
    logic [IW-1:0] idle_cnt;

    assign mode_change = mode_sync ^ mode_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned a = 0; a < 64; a++)
                    frame_buf[b][a] <= '0;
            byte_idx  <= '0;
            wr_sel    <= 1'b0;
            swap_pend <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            swap_pend <= 1'b0;
            if (swap_pend) wr_sel <= ~wr_sel;
            if (byte_valid) idle_cnt <= '0;
            else if (idle_cnt != IW'(FRAME_TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
            if (mode_change || !mode_sync) begin
                byte_idx <= '0;
            end else if (byte_valid) begin
                frame_buf[wr_sel][byte_idx] <= rx_shift;
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == 6'd63) swap_pend <= 1'b1;
            end else if (idle_cnt == IW'(FRAME_TIMEOUT) && byte_idx != '0) begin
                byte_idx <= '0;
            end
        end
    end

    logic [DW-1:0] demo_cnt;
    logic [2:0]    demo_step;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            demo_cnt  <= '0;
            demo_step <= '0;
        end else if (demo_cnt == DW'(DEMO_CLKS - 1)) begin
            demo_cnt  <= '0;
            demo_step <= demo_step + 1'b1;
        end else begin
            demo_cnt <= demo_cnt + 1'b1;
        end
    end

    logic [LW-1:0] slot_t;
    logic [2:0]    layer;
    logic [7:0]    slot_rows [8];

    // Rows of the whole layer are captured at t=0 so a swap cannot tear a layer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_t <= '0;
            layer  <= '0;
            for (int unsigned r = 0; r < 8; r++) slot_rows[r] <= '0;
        end else begin
            if (slot_t == LW'(LAYER_CLKS - 1)) begin
                slot_t <= '0;
                layer  <= layer + 1'b1;
            end else begin
                slot_t <= slot_t + 1'b1;
            end
            if (slot_t == '0) begin
                for (int unsigned r = 0; r < 8; r++)
                    slot_rows[r] <= mode_sync ? frame_buf[~wr_sel][{layer, 3'(r)}]
                                              : ((layer == demo_step) ? 8'hFF : 8'h00);
            end
        end
    end

    logic [7:0] csn_d, row_d, cs_d;
    logic [2:0] r_idx;
    always_comb begin
        csn_d = 8'hFF;
        row_d = '0;
        cs_d  = '0;
        r_idx = 3'((slot_t - LW'(1)) >> 1);
        if (slot_t >= LW'(1) && slot_t <= LW'(16)) begin
            row_d = slot_rows[r_idx];
            if (slot_t[0]) cs_d = 8'h01 << r_idx;
        end else if (slot_t >= LW'(17)) begin
            csn_d = ~(8'h01 << layer);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            high_csn <= 8'hFF;
            row      <= '0;
            row_cs   <= '0;
        end else begin
            high_csn <= csn_d;
            row      <= row_d;
            row_cs   <= cs_d;
        end
    end

endmodule

// File: tb/tb_lightcube8_ctrl.sv
// Bench for lightcube8_ctrl: randomized UART frames against a cycle-count
// based display model and a decoded echo stream.
module tb_lightcube8_ctrl;
    localparam int BC = 8;
    localparam int LC = 24;
    localparam int DC = 1000;
    localparam int FT = 400;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] switch = '0;
    logic        tx;
    logic [7:0]  high_csn, row, row_cs;

    always #5 clk = ~clk;

    lightcube8_ctrl #(
        .CLK_FREQ(800_000), .BAUD(100_000), .FRAME_TIMEOUT(FT),
        .LAYER_CLKS(LC), .DEMO_CLKS(DC)
    ) dut (
        .clk(clk), .resetn(resetn), .switch(switch), .rx(rx), .tx(tx),
        .high_csn(high_csn), .row(row), .row_cs(row_cs)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int chg_cyc = -1000;
    bit run_chk = 1'b0;
    bit mode_model = 1'b0;
    logic [7:0] disp_model [64];
    logic [7:0] frm [64];
    logic [7:0] exp_echo [$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_row(input int L, input int r, input int s);
        if (mode_model) return disp_model[L*8 + r];
        return (((s - 1) / DC) % 8 == L) ? 8'hFF : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Outputs seen after posedge n reflect slot position n-1 since release.
    logic [7:0] obs [16];
    always @(negedge clk) begin : cmp
        int t, L, s;
        logic [7:0] e_csn, e_cs;
        if (run_chk && resetn && cyc >= 1) begin
            t = (cyc - 1) % LC;
            L = ((cyc - 1) / LC) % 8;
            e_csn = 8'hFF;
            if (t >= 17) e_csn = ~(8'h01 << L);
            e_cs = 8'h00;
            if (t >= 1 && t <= 16 && (t % 2) == 1) e_cs = 8'h01 << ((t - 1) / 2);
            check8("high_csn", high_csn, e_csn);
            check8("row_cs", row_cs, e_cs);
            if (t >= 1 && t <= 16) obs[t-1] = row;
            if (t == LC - 1) begin
                s = cyc - t;
                if (chg_cyc + 24 <= s)
                    for (int k = 0; k < 16; k++)
                        check8($sformatf("row_L%0d_r%0d", L, k / 2), obs[k], exp_row(L, k / 2, s));
            end
        end
    end

    initial begin : txmon
        logic [10:0] f;
        logic [7:0]  e;
        logic        prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (resetn && prev && !tx) begin
                repeat (BC / 2 - 1) @(negedge clk);
                f[0] = tx;
                for (int b = 1; b < 11; b++) begin
                    repeat (BC) @(negedge clk);
                    f[b] = tx;
                end
                if (exp_echo.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL echo_extra: got %02h expected none", f[8:1]);
                end else begin
                    e = exp_echo.pop_front();
                    check8("echo_data", f[8:1], e);
                    check8("echo_extra_bit", {7'b0, f[9]}, {7'b0, e[0]});
                    check8("echo_start", {7'b0, f[0]}, 8'h00);
                    check8("echo_stop", {7'b0, f[10]}, 8'h01);
                end
            end
            prev = tx;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_slot(input int layer, input int t, input int min_s, input string name);
        int n;
        n = 0;
        while (!((cyc - 1) % LC == t && ((cyc - 1) / LC) % 8 == layer && cyc - t > min_s)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s: slot not reached got timeout expected layer %0d", name, layer);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop, input int gap);
        logic [10:0] f;
        f = {stop, 1'($urandom_range(0, 1)), d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            rx = f[b];
            repeat (BC) @(negedge clk);
        end
        if (!stop) repeat (BC) @(negedge clk);
        rx = 1'b1;
        if (stop) exp_echo.push_back(d);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int n, input int bad_at, input int glitch_at);
        for (int k = 0; k < n; k++) begin
            if (k == bad_at) send_byte(8'($urandom), 1'b0, 16);
            if (k == glitch_at) begin
                rx = 1'b0;
                repeat (2) @(negedge clk);
                rx = 1'b1;
                repeat (12) @(negedge clk);
            end
            send_byte(frm[k], 1'b1, $urandom_range(0, 12));
        end
        if (n == 64) begin
            disp_model = frm;
            chg_cyc = cyc;
        end
    endtask

    task automatic random_frame();
        for (int k = 0; k < 64; k++) frm[k] = 8'($urandom);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) disp_model[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check8("rst_high_csn", high_csn, 8'hFF);
            check8("rst_row", row, 8'h00);
            check8("rst_row_cs", row_cs, 8'h00);
            check8("rst_tx", {7'b0, tx}, 8'h01);
            repeat (5) @(negedge clk);
        end
        resetn = 1'b1;
        run_chk = 1'b1;

        wait_cyc(2);
        check8("demo_l0_row", row, 8'hFF);
        check8("demo_l0_cs", row_cs, 8'h01);
        wait_cyc(17);
        check8("blank_before_enable", high_csn, 8'hFF);
        wait_cyc(18);
        check8("first_enable", high_csn, 8'hFE);

        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1, 4);

        wait_slot(1, 1, DC, "demo_step1");
        check8("demo_l1_row", row, 8'hFF);
        wait_slot(0, 1, cyc, "demo_l0_off");
        check8("demo_l0_off_row", row, 8'h00);

        switch = {15'($urandom), 1'b1};
        mode_model = 1'b1;
        chg_cyc = cyc;
        repeat (300) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 64; j++) frm[j] = 8'(i ^ j);
            send_frame(64, -1, -1);
            if (i == 0) begin
                wait_slot(2, 1, chg_cyc, "layer2_slot");
                for (int k = 0; k < 16; k++) begin
                    check8("l2_row", row, 8'h10 + 8'(k / 2));
                    check8("l2_row_cs", row_cs, (k % 2 == 0) ? (8'h01 << (k / 2)) : 8'h00);
                    @(negedge clk);
                end
            end
            repeat (20) @(negedge clk);
        end

        random_frame();
        send_frame(20, -1, -1);
        repeat (FT + 200) @(negedge clk);
        random_frame();
        send_frame(64, -1, -1);
        repeat (200) @(negedge clk);

        random_frame();
        send_frame(64, 10, 30);
        repeat (200) @(negedge clk);

        random_frame();
        send_frame(30, -1, -1);
        switch[0] = 1'b0;
        mode_model = 1'b0;
        chg_cyc = cyc;
        repeat (300) @(negedge clk);
        switch[0] = 1'b1;
        mode_model = 1'b1;
        chg_cyc = cyc;
        repeat (400) @(negedge clk);
        random_frame();
        send_frame(64, -1, -1);
        repeat (400) @(negedge clk);

        for (int n = 0; n < 2000 && exp_echo.size() != 0; n++) @(negedge clk);
        check8("echo_drain", 8'(exp_echo.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
